// File: rtl/ring_credit_node_pkg.sv
// ----------------------------------------------------------------------------
// NetworkPkg
// Shared ring-network definitions: node addressing, the packet format carried
// on every ring link, and the output-arbiter grant encoding.
//   NUMNODES   : number of addressable ring nodes
//   ID_SIZE    : width of a node address
//   DATA_WIDTH : payload width of one packet
//   pkt_t      : {src, dest, data}, packed so it travels as a flat vector
//   grant_e    : who owns the downstream link in a given cycle
// ----------------------------------------------------------------------------
package NetworkPkg;

    localparam int NUMNODES   = 8;
    localparam int ID_SIZE    = $clog2(NUMNODES);
    localparam int DATA_WIDTH = 8;

    typedef struct packed {
        logic [ID_SIZE-1:0]    src;
        logic [ID_SIZE-1:0]    dest;
        logic [DATA_WIDTH-1:0] data;
    } pkt_t;

    localparam int PKT_WIDTH = $bits(pkt_t);

    typedef enum logic [1:0] {
        GRANT_NONE    = 2'd0,
        GRANT_TRANSIT = 2'd1,
        GRANT_INJECT  = 2'd2
    } grant_e;

    // Each pop frees exactly one slot of the shared pool, so the credit
    // handed back upstream is just the number of pops this cycle.
    function automatic logic [1:0] pop_credits(input logic pop_a, input logic pop_b);
        return {1'b0, pop_a} + {1'b0, pop_b};
    endfunction

endpackage

// File: rtl/ring_credit_node_fifo.sv
// ----------------------------------------------------------------------------
// fifo_sync
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// data_out whenever the FIFO is not empty (zero when empty).
//   clk, rst_l : clock, asynchronous active-low reset (empties the FIFO)
//   we, data_in: push request and data; ignored while full
//   re         : pop request; ignored while empty
//   data_out   : current head entry
//   full, empty: occupancy flags
//   count      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ----------------------------------------------------------------------------
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   we,
    input  logic [WIDTH-1:0]       data_in,
    input  logic                   re,
    output logic [WIDTH-1:0]       data_out,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_write;
    logic             do_read;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_write = we && !full;
    assign do_read  = re && !empty;
    assign data_out = empty ? '0 : mem[rd_ptr];

    // Storage array carries no reset; stale entries are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers wrap modulo DEPTH; a simultaneous push and pop leaves the
    // count unchanged.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, do_read})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ring_credit_node.sv
// ----------------------------------------------------------------------------
// ring_credit_node
// One stop on a unidirectional credit-flow-controlled ring. Arriving packets
// are either ejected to the local core (dest == NODE_ID) or queued for
// forwarding; the local core can inject new packets onto the ring. Both local
// queues share one pool of DEPTH slots, which is exactly the credit count the
// upstream neighbour holds for this node.
//   clk, rst_l          : clock, asynchronous active-low reset
//   ring_in_valid/_pkt  : packet from upstream
//   ring_in_credit      : slots freed this cycle, returned upstream (0..2)
//   ring_out_valid/_pkt : registered packet to downstream
//   ring_out_credit     : credits returned by downstream (0..2)
//   inj_valid/_pkt      : core injection offer
//   inj_ready           : injection taken this cycle
//   ej_valid/_pkt       : head of the eject queue
//   ej_ready            : core consumes the ejected packet
//   err                 : sticky protocol error (drop, self-injection, credit
//                         overflow)
// ----------------------------------------------------------------------------
module ring_credit_node
    import NetworkPkg::*;
#(
    parameter int NODE_ID    = 0,
    parameter int DEPTH      = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       ring_in_valid,
    input  pkt_t       ring_in_pkt,
    output logic [1:0] ring_in_credit,
    output logic       ring_out_valid,
    output pkt_t       ring_out_pkt,
    input  logic [1:0] ring_out_credit,
    input  logic       inj_valid,
    input  pkt_t       inj_pkt,
    output logic       inj_ready,
    output logic       ej_valid,
    output pkt_t       ej_pkt,
    input  logic       ej_ready,
    output logic       err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]      CREDIT_MAX   = CW'(DEPTH);
    localparam logic [SW-1:0]      STARVE_LIMIT = SW'(STARVE_MAX);
    localparam logic [ID_SIZE-1:0] MY_ID        = ID_SIZE'(NODE_ID);

    // Queue status
    logic [CW-1:0] t_count;
    logic [CW-1:0] e_count;
    logic          t_empty;
    logic          e_empty;
    logic          t_full;
    logic          e_full;
    pkt_t          t_head;
    pkt_t          e_head;
    logic          t_we;
    logic          e_we;
    logic          t_re;
    logic          e_re;

    // Arrival / pool
    logic [CW:0]   occupancy;
    logic          pool_full;
    logic          arrive_local;
    logic          drop_err;

    // Arbitration
    grant_e        grant;
    logic          send;
    logic          has_credit;
    logic          inj_self;
    logic          inj_req;
    logic          starved;

    // Credit and starve bookkeeping
    logic [CW-1:0] credits;
    logic [CW-1:0] credits_next;
    logic [CW:0]   credit_sum;
    logic          credit_over;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_next;

    // Arrival steering. The pool limit is judged on occupancy before this
    // cycle's pops: slots freed now are only usable by upstream next cycle.
    assign occupancy    = {1'b0, t_count} + {1'b0, e_count};
    assign pool_full    = (occupancy >= {1'b0, CREDIT_MAX});
    assign arrive_local = (ring_in_pkt.dest == MY_ID);
    assign t_we         = ring_in_valid && !pool_full && !arrive_local;
    assign e_we         = ring_in_valid && !pool_full &&  arrive_local;
    assign drop_err     = ring_in_valid && pool_full;

    fifo_sync #(
        .WIDTH (PKT_WIDTH),
        .DEPTH (DEPTH)
    ) u_transit (
        .clk      (clk),
        .rst_l    (rst_l),
        .we       (t_we),
        .data_in  (ring_in_pkt),
        .re       (t_re),
        .data_out (t_head),
        .full     (t_full),
        .empty    (t_empty),
        .count    (t_count)
    );

    fifo_sync #(
        .WIDTH (PKT_WIDTH),
        .DEPTH (DEPTH)
    ) u_eject (
        .clk      (clk),
        .rst_l    (rst_l),
        .we       (e_we),
        .data_in  (ring_in_pkt),
        .re       (e_re),
        .data_out (e_head),
        .full     (e_full),
        .empty    (e_empty),
        .count    (e_count)
    );

    // Self-addressed injections never touch the link: they are swallowed and
    // flagged, and do not compete with transit traffic. Everything here is
    // gated by rst_l so handshakes read as idle while reset is held.
    assign has_credit = rst_l && (credits != '0);
    assign inj_self   = rst_l && inj_valid && (inj_pkt.dest == MY_ID);
    assign inj_req    = rst_l && inj_valid && (inj_pkt.dest != MY_ID);
    assign starved    = (starve_cnt >= STARVE_LIMIT);

    // Output arbiter: transit first, unless the transit queue is empty or the
    // core has been passed over STARVE_MAX times in a row.
    always_comb begin
        grant = GRANT_NONE;
        if (has_credit) begin
            if (inj_req && (starved || t_empty)) begin
                grant = GRANT_INJECT;
            end else if (!t_empty) begin
                grant = GRANT_TRANSIT;
            end
        end
    end

    assign send           = (grant != GRANT_NONE);
    assign t_re           = (grant == GRANT_TRANSIT);
    assign e_re           = rst_l && ej_ready && !e_empty;
    assign inj_ready      = (grant == GRANT_INJECT) || inj_self;
    assign ring_in_credit = pop_credits(t_re, e_re);
    assign ej_valid       = !e_empty;
    assign ej_pkt         = e_head;

    // Downstream credit tracking: a send and a return in the same cycle net
    // out. A send needs credits > 0, so the subtraction never underflows; an
    // excess return is clamped and reported.
    always_comb begin
        credit_sum   = {1'b0, credits} - {{CW{1'b0}}, send}
                     + {{(CW-1){1'b0}}, ring_out_credit};
        credit_over  = (credit_sum > {1'b0, CREDIT_MAX});
        credits_next = credit_over ? CREDIT_MAX : credit_sum[CW-1:0];
    end

    // Starvation counter: counts only denials that happened while the link
    // could have been used, saturates at the limit, and clears on a grant or
    // when the core withdraws.
    always_comb begin
        starve_next = starve_cnt;
        if (!inj_req || grant == GRANT_INJECT) begin
            starve_next = '0;
        end else if (has_credit && !starved) begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            credits    <= CREDIT_MAX;
            starve_cnt <= '0;
        end else begin
            credits    <= credits_next;
            starve_cnt <= starve_next;
        end
    end

    // Registered link output; the payload holds its last value between sends.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ring_out_valid <= 1'b0;
            ring_out_pkt   <= '0;
        end else begin
            ring_out_valid <= send;
            if (grant == GRANT_INJECT) begin
                ring_out_pkt <= inj_pkt;
            end else if (grant == GRANT_TRANSIT) begin
                ring_out_pkt <= t_head;
            end
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            err <= 1'b0;
        end else if (drop_err || inj_self || credit_over) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ring_credit_node.sv
// ----------------------------------------------------------------------------
// tb_ring_credit_node
// Directed bench for ring_credit_node with NODE_ID=2, DEPTH=8, STARVE_MAX=4.
// Inputs change 1 time unit after a rising edge; registered outputs are read
// right after the edge, combinational outputs after inputs settle.
// Timing reference: a packet written at edge E is popped (credit returned)
// in the cycle after E and shows on ring_out at edge E+1.
// ----------------------------------------------------------------------------
module tb_ring_credit_node;
    import NetworkPkg::*;

    logic       clk;
    logic       rst_l;
    logic       ring_in_valid;
    pkt_t       ring_in_pkt;
    logic [1:0] ring_in_credit;
    logic       ring_out_valid;
    pkt_t       ring_out_pkt;
    logic [1:0] ring_out_credit;
    logic       inj_valid;
    pkt_t       inj_pkt;
    logic       inj_ready;
    logic       ej_valid;
    pkt_t       ej_pkt;
    logic       ej_ready;
    logic       err;

    int compared;
    int mismatched;

    ring_credit_node #(
        .NODE_ID    (2),
        .DEPTH      (8),
        .STARVE_MAX (4)
    ) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .ring_in_valid   (ring_in_valid),
        .ring_in_pkt     (ring_in_pkt),
        .ring_in_credit  (ring_in_credit),
        .ring_out_valid  (ring_out_valid),
        .ring_out_pkt    (ring_out_pkt),
        .ring_out_credit (ring_out_credit),
        .inj_valid       (inj_valid),
        .inj_pkt         (inj_pkt),
        .inj_ready       (inj_ready),
        .ej_valid        (ej_valid),
        .ej_pkt          (ej_pkt),
        .ej_ready        (ej_ready),
        .err             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic pkt_t pk(input logic [2:0] s, input logic [2:0] d, input logic [7:0] v);
        pkt_t p;
        p.src  = s;
        p.dest = d;
        p.data = v;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input pkt_t p);
        ring_in_valid = valid;
        ring_in_pkt   = p;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        compared        = 0;
        mismatched      = 0;
        rst_l           = 1'b0;
        ring_in_valid   = 1'b0;
        ring_in_pkt     = '0;
        ring_out_credit = 2'd0;
        inj_valid       = 1'b0;
        inj_pkt         = '0;
        ej_ready        = 1'b0;

        // Reset state
        #12;
        checkOutput("rst_out_valid", 32'(ring_out_valid), 32'd0);
        checkOutput("rst_ej_valid", 32'(ej_valid), 32'd0);
        checkOutput("rst_in_credit", 32'(ring_in_credit), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_credits", 32'(dut.credits), 32'd8);
        @(negedge clk);
        rst_l = 1'b1;
        tick();

        // Idle pass-through of a transit packet
        applyStimulus(1'b1, pk(3'd1, 3'd5, 8'hA5));
        tick();
        applyStimulus(1'b0, '0);
        #1;
        checkOutput("pass_credit_pop", 32'(ring_in_credit), 32'd1);
        checkOutput("pass_not_yet_out", 32'(ring_out_valid), 32'd0);
        tick();
        checkOutput("pass_out_valid", 32'(ring_out_valid), 32'd1);
        checkOutput("pass_out_pkt", 32'(ring_out_pkt), 32'(pk(3'd1, 3'd5, 8'hA5)));
        checkOutput("pass_credits_7", 32'(dut.credits), 32'd7);
        checkOutput("pass_credit_idle", 32'(ring_in_credit), 32'd0);
        ring_out_credit = 2'd1;
        tick();
        ring_out_credit = 2'd0;
        checkOutput("pass_out_idle", 32'(ring_out_valid), 32'd0);
        checkOutput("pass_credits_back", 32'(dut.credits), 32'd8);

        // Local delivery held by the core, then consumed
        applyStimulus(1'b1, pk(3'd3, 3'd2, 8'h3C));
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("ej_valid_held", 32'(ej_valid), 32'd1);
        checkOutput("ej_pkt_head", 32'(ej_pkt), 32'(pk(3'd3, 3'd2, 8'h3C)));
        checkOutput("ej_no_credit_held", 32'(ring_in_credit), 32'd0);
        tick();
        checkOutput("ej_still_valid", 32'(ej_valid), 32'd1);
        ej_ready = 1'b1;
        #1;
        checkOutput("ej_pop_credit", 32'(ring_in_credit), 32'd1);
        tick();
        ej_ready = 1'b0;
        checkOutput("ej_empty_after_pop", 32'(ej_valid), 32'd0);
        checkOutput("ej_no_link_use", 32'(ring_out_valid), 32'd0);

        // Injection starvation behind continuous transit traffic
        applyStimulus(1'b1, pk(3'd1, 3'd4, 8'h10));
        tick();
        inj_valid = 1'b1;
        inj_pkt   = pk(3'd2, 3'd6, 8'h77);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1'b1, pk(3'd1, 3'd4, 8'h10 + 8'(i)));
            #1;
            checkOutput($sformatf("starve_inj_ready_%0d", i), 32'(inj_ready), (i == 5) ? 32'd1 : 32'd0);
            tick();
        end
        applyStimulus(1'b0, '0);
        inj_valid = 1'b0;
        checkOutput("starve_out_is_inj", 32'(ring_out_pkt), 32'(pk(3'd2, 3'd6, 8'h77)));
        checkOutput("starve_cnt_cleared", 32'(dut.starve_cnt), 32'd0);
        #1;
        checkOutput("starve_transit_resumes", 32'(ring_in_credit), 32'd1);
        tick();
        checkOutput("starve_fifo_order_a", 32'(ring_out_pkt), 32'(pk(3'd1, 3'd4, 8'h14)));
        tick();
        checkOutput("starve_fifo_order_b", 32'(ring_out_pkt), 32'(pk(3'd1, 3'd4, 8'h15)));
        tick();
        checkOutput("starve_drained", 32'(ring_out_valid), 32'd0);
        checkOutput("starve_credits_1", 32'(dut.credits), 32'd1);
        ring_out_credit = 2'd2;
        tick();
        tick();
        tick();
        ring_out_credit = 2'd1;
        tick();
        ring_out_credit = 2'd0;
        checkOutput("starve_credits_restored", 32'(dut.credits), 32'd8);
        checkOutput("starve_no_err", 32'(err), 32'd0);

        // Credit exhaustion with no returns from downstream
        inj_valid = 1'b1;
        inj_pkt   = pk(3'd2, 3'd6, 8'h55);
        for (int i = 0; i < 8; i++) begin
            #1;
            checkOutput($sformatf("exhaust_send_%0d", i), 32'(inj_ready), 32'd1);
            tick();
        end
        checkOutput("exhaust_last_sent", 32'(ring_out_valid), 32'd1);
        checkOutput("exhaust_credits_0", 32'(dut.credits), 32'd0);
        #1;
        checkOutput("exhaust_blocked", 32'(inj_ready), 32'd0);
        tick();
        checkOutput("exhaust_no_valid", 32'(ring_out_valid), 32'd0);
        ring_out_credit = 2'd1;
        #1;
        checkOutput("exhaust_still_blocked", 32'(inj_ready), 32'd0);
        tick();
        ring_out_credit = 2'd0;
        #1;
        checkOutput("exhaust_resume_ready", 32'(inj_ready), 32'd1);
        tick();
        inj_valid = 1'b0;
        checkOutput("exhaust_resume_valid", 32'(ring_out_valid), 32'd1);
        checkOutput("exhaust_credits_0_again", 32'(dut.credits), 32'd0);
        tick();
        checkOutput("exhaust_single_send", 32'(ring_out_valid), 32'd0);
        ring_out_credit = 2'd2;
        tick();
        tick();
        tick();
        tick();
        ring_out_credit = 2'd0;
        checkOutput("exhaust_credits_restored", 32'(dut.credits), 32'd8);
        checkOutput("exhaust_no_err", 32'(err), 32'd0);

        // Fill the shared pool through the eject queue, then overflow it
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, pk(3'd1, 3'd2, 8'h40 + 8'(i)));
            tick();
        end
        checkOutput("pool_full_no_err", 32'(err), 32'd0);
        checkOutput("pool_eject_count", 32'(dut.u_eject.count), 32'd8);
        applyStimulus(1'b1, pk(3'd1, 3'd2, 8'h48));
        tick();
        applyStimulus(1'b0, '0);
        checkOutput("pool_drop_err", 32'(err), 32'd1);
        checkOutput("pool_drop_count", 32'(dut.u_eject.count), 32'd8);
        ej_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("pool_drain_pkt_%0d", i), 32'(ej_pkt), 32'(pk(3'd1, 3'd2, 8'h40 + 8'(i))));
            checkOutput($sformatf("pool_drain_credit_%0d", i), 32'(ring_in_credit), 32'd1);
            tick();
        end
        ej_ready = 1'b0;
        checkOutput("pool_next_head", 32'(ej_pkt), 32'(pk(3'd1, 3'd2, 8'h45)));
        checkOutput("pool_err_sticky", 32'(err), 32'd1);

        // Reset while three packets are buffered and a send is on the link
        inj_valid = 1'b1;
        inj_pkt   = pk(3'd2, 3'd7, 8'h99);
        tick();
        checkOutput("midrst_sending", 32'(ring_out_valid), 32'd1);
        ej_ready = 1'b1;
        rst_l    = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(ring_out_valid), 32'd0);
        checkOutput("midrst_out_pkt", 32'(ring_out_pkt), 32'd0);
        checkOutput("midrst_ej_valid", 32'(ej_valid), 32'd0);
        checkOutput("midrst_inj_ready", 32'(inj_ready), 32'd0);
        checkOutput("midrst_in_credit", 32'(ring_in_credit), 32'd0);
        checkOutput("midrst_err", 32'(err), 32'd0);
        inj_valid = 1'b0;
        ej_ready  = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        tick();
        checkOutput("postrst_credits", 32'(dut.credits), 32'd8);
        checkOutput("postrst_ej_empty", 32'(ej_valid), 32'd0);

        // Returning a credit the node never spent saturates and flags
        ring_out_credit = 2'd1;
        tick();
        ring_out_credit = 2'd0;
        checkOutput("overflow_credits_sat", 32'(dut.credits), 32'd8);
        checkOutput("overflow_err", 32'(err), 32'd1);

        // Self-addressed injection is swallowed and flagged
        rst_l = 1'b0;
        #2;
        rst_l = 1'b1;
        tick();
        checkOutput("self_err_clear", 32'(err), 32'd0);
        inj_valid = 1'b1;
        inj_pkt   = pk(3'd2, 3'd2, 8'hEE);
        #1;
        checkOutput("self_inj_ready", 32'(inj_ready), 32'd1);
        tick();
        inj_valid = 1'b0;
        checkOutput("self_no_send", 32'(ring_out_valid), 32'd0);
        checkOutput("self_err_set", 32'(err), 32'd1);
        checkOutput("self_no_credit_used", 32'(dut.credits), 32'd8);
        checkOutput("self_not_ejected", 32'(ej_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ring_credit_node.md
RING_CREDIT_NODE -- requirements
Module: ring_credit_node

Interface
REQ-001 SHALL take parameters: NODE_ID (default 0, this node's ring address); DEPTH (default 8, per-FIFO depth and credit pool size, power of 2, >=2); STARVE_MAX (default 4, consecutive injection denials before forced injection grant).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst_l  input  1  asynchronous active-low reset.
REQ-005 ring_in_valid  input  1  packet arriving from upstream node this cycle.
REQ-006 ring_in_pkt  input  pkt_t  arriving packet.
REQ-007 ring_in_credit  output  2  credits returned to upstream this cycle (0..2).
REQ-008 ring_out_valid  output  1  registered; packet sent to downstream this cycle.
REQ-009 ring_out_pkt  output  pkt_t  registered outgoing packet.
REQ-010 ring_out_credit  input  2  credits returned by downstream this cycle (0..2).
REQ-011 inj_valid  input  1  core offers a packet.
REQ-012 inj_pkt  input  pkt_t  core packet.
REQ-013 inj_ready  output  1  injection accepted this cycle (valid&&ready = transfer).
REQ-014 ej_valid  output  1  ejected packet available.
REQ-015 ej_pkt  output  pkt_t  head of eject FIFO.
REQ-016 ej_ready  input  1  core consumes ejected packet.
REQ-017 err  output  1  sticky protocol-error flag.

Function
REQ-018 Arrival with dest==NODE_ID SHALL be written to eject FIFO; otherwise to transit FIFO; write lands on the same rising edge.
REQ-019 Transit+eject occupancy SHALL never exceed DEPTH (shared credit pool); arrival when pool full SHALL be dropped and set err.
REQ-020 ring_in_credit SHALL equal (transit pop) + (eject pop) in that cycle, combinational.
REQ-021 Credit counter SHALL reset to DEPTH; next = cur - ring_out_valid_next + ring_out_credit; simultaneous send and return SHALL net; result exceeding DEPTH SHALL saturate at DEPTH and set err.
REQ-022 Output arbiter SHALL grant only when credits>0; transit head has priority over injection.
REQ-023 Starve counter SHALL increment each cycle inj_valid is denied while credits>0; on reaching STARVE_MAX injection SHALL win next arbitration; counter clears on injection grant or inj_valid low.
REQ-024 Granted packet SHALL appear on ring_out_valid/ring_out_pkt at the next edge; idle pass-through latency 2 cycles (arrive edge t, head t+1, out t+2).
REQ-025 inj_ready SHALL be combinational: high iff injection wins arbitration this cycle.
REQ-026 Injected packet with dest==NODE_ID SHALL be accepted (inj_ready=1, no credit consumed), discarded, and set err.
REQ-027 ej_valid = eject FIFO non-empty; pop on ej_valid&&ej_ready; simultaneous push and pop SHALL keep count unchanged.
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; count width $clog2(DEPTH)+1.

Reset
REQ-029 On rst_l low, asynchronously: FIFOs empty, credits=DEPTH, starve counter 0, ring_out_valid 0, ring_out_pkt 0, err 0; ej_valid, inj_ready, ring_in_credit evaluate to 0.
REQ-030 Reset mid-transfer SHALL discard all buffered packets; no credit returned for them.

Structure
REQ-031 pkt_t (src, dest, data), ID_SIZE, DATA_WIDTH, NUMNODES SHALL live in NetworkPkg.
REQ-032 One sub-module fifo_sync (WIDTH, DEPTH; we, re, data_out, full, empty, count) SHALL be instantiated twice (transit, eject).

Verification
REQ-033 NODE_ID=2, idle: ring_in pkt dest=5 at edge 0 -> ring_out_valid at edge 2 same pkt, credits 8->7, ring_in_credit=1 at edge 1.
REQ-034 Arrival dest=2 with ej_ready=0, then ej_ready=1 -> ej_valid from edge 1, popped, ring_in_credit=1 on pop cycle.
REQ-035 Transit continuously busy, inj_valid=1, STARVE_MAX=4 -> injection granted on 5th cycle, counter cleared.
REQ-036 ring_out_credit=0 for 8 sends -> credits=0, no further ring_out_valid; ring_out_credit=1 -> one send resumes.
REQ-037 Credit pool full (8 held) plus extra arrival -> packet dropped, err=1 sticky until rst_l.
REQ-038 rst_l asserted with 3 packets buffered -> all outputs 0 immediately, credits=8 after release.
